interrupt_controller_16: RTL

INTERRUPT_CONTROLLER_16 -- requirements
Module: interrupt_controller_16

---
 rtl/interrupt_controller_pkg.sv | 13 +
 rtl/prio_find_16.sv | 22 ++
 rtl/interrupt_controller_16.sv | 105 ++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// Shared types and sizes for the 16-source interrupt controller.
package interrupt_controller_pkg;

  localparam int NUM_SRC = 16;
  localparam int ID_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/prio_find_16.sv
// Highest-set-bit search over 16 request lines; bit 15 wins.
module prio_find_16
  import interrupt_controller_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_vec,
  output logic [ID_W-1:0]    idx,
  output logic               valid
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req_vec[i]) begin
        idx   = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller_16.sv
// 16-source interrupt controller: rising-edge pending capture, fixed priority,
// single request/service handshake with an acknowledge timeout.
module interrupt_controller_16
  import interrupt_controller_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               en_wr,
  input  logic [NUM_SRC-1:0] en_data,
  output logic [NUM_SRC-1:0] irq_en,
  output logic [NUM_SRC-1:0] pending,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               in_service,
  output logic               timeout
);

  localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

  irq_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] en_q, pend_q, pend_d, prev_q, rise, clr_mask, eff;
  logic [7:0]         cnt_q, cnt_d;
  logic [ID_W-1:0]    id_q, id_d, top_id;
  logic               top_valid, tmo_q, tmo_d;

  assign rise = irq_in & ~prev_q;
  assign eff  = pend_q & en_q;

  prio_find_16 u_prio (
    .req_vec (eff),
    .idx     (top_id),
    .valid   (top_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Acknowledge is tested before expiry so a late ack still wins.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    tmo_d    = 1'b0;
    clr_mask = '0;
    case (state_q)
      IDLE: begin
        if (top_valid) begin
          state_d = REQ;
          id_d    = top_id;
          cnt_d   = '0;
        end
      end
      REQ: begin
        if (irq_ack) begin
          clr_mask = {{(NUM_SRC-1){1'b0}}, 1'b1} << id_q;
          state_d  = SVC;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SVC: begin
        if (irq_eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge on the acknowledged source re-arms it in the same cycle.
    pend_d = (pend_q & ~clr_mask) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= '0;
      pend_q <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
      id_q   <= '0;
      tmo_q  <= 1'b0;
    end else begin
      if (en_wr) en_q <= en_data;
      pend_q <= pend_d;
      prev_q <= irq_in;
      cnt_q  <= cnt_d;
      id_q   <= id_d;
      tmo_q  <= tmo_d;
    end
  end

  assign irq_en     = en_q;
  assign pending    = pend_q;
  assign irq_req    = (state_q == REQ);
  assign in_service = (state_q == SVC);
  assign irq_id     = id_q;
  assign timeout    = tmo_q;

endmodule
